// File: rtl/m506_filtered_converter.sv
// Multi-channel negative-logic input converter: gate, synchronise, debounce, pulse on change.
// Optional sticky assert flags per channel when M506F_FLAG_EN is defined.
module m506_filtered_converter #(
  parameter int unsigned CHANNELS = 6,
  parameter int unsigned GATES    = 3,
  parameter int unsigned DEBOUNCE = 4,
  parameter int unsigned CNT_W    = 3
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [CHANNELS-1:0]         in_n,
  input  logic [CHANNELS*GATES-1:0]   gate,
  output logic [CHANNELS-1:0]         out_n,
  output logic [CHANNELS-1:0]         assert_pulse,
  output logic [CHANNELS-1:0]         release_pulse
`ifdef M506F_FLAG_EN
  ,
  output logic [CHANNELS-1:0]         flag,
  input  logic [CHANNELS-1:0]         flag_clr
`endif
);

  logic [CHANNELS-1:0] raw;
  logic [CHANNELS-1:0] sync1_q, sync2_q;
  logic [CHANNELS-1:0] filt_q, filt_d;
  logic [CHANNELS-1:0] assert_q, assert_d;
  logic [CHANNELS-1:0] release_q, release_d;
  logic [CNT_W-1:0]    cnt_q [CHANNELS];
  logic [CNT_W-1:0]    cnt_d [CHANNELS];

  always_comb begin
    for (int i = 0; i < int'(CHANNELS); i++) begin
      raw[i] = ~in_n[i] & (&gate[i*GATES +: GATES]);
    end
  end

  // Any return of sync2 to the accepted level restarts the count from zero.
  always_comb begin
    filt_d    = filt_q;
    assert_d  = '0;
    release_d = '0;
    for (int i = 0; i < int'(CHANNELS); i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != filt_q[i]) begin
        if (cnt_q[i] == CNT_W'(DEBOUNCE - 1)) begin
          filt_d[i]    = sync2_q[i];
          assert_d[i]  = sync2_q[i];
          release_d[i] = ~sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      filt_q    <= '0;
      assert_q  <= '0;
      release_q <= '0;
      for (int i = 0; i < int'(CHANNELS); i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q   <= raw;
      sync2_q   <= sync1_q;
      filt_q    <= filt_d;
      assert_q  <= assert_d;
      release_q <= release_d;
      for (int i = 0; i < int'(CHANNELS); i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign out_n         = ~filt_q;
  assign assert_pulse  = assert_q;
  assign release_pulse = release_q;

`ifdef M506F_FLAG_EN
  logic [CHANNELS-1:0] flag_q, flag_d;

  // Set has priority over a simultaneous clear.
  always_comb begin
    flag_d = (flag_q & ~flag_clr) | assert_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flag_q <= '0;
    end else begin
      flag_q <= flag_d;
    end
  end

  assign flag = flag_q;
`else
  // Flag feature absent in this build.
`endif

endmodule

// File: tb/tb_m506_filtered_converter.sv
// Scoreboard bench for m506_filtered_converter: directed stimulus pushes expected pulse events,
// a negedge monitor pops and compares them. Define M506F_FLAG_EN to also exercise the flags.
module tb_m506_filtered_converter;

  logic        clk;
  logic        reset;
  logic [5:0]  in_n;
  logic [17:0] gate;
  logic [5:0]  out_n;
  logic [5:0]  assert_pulse;
  logic [5:0]  release_pulse;
`ifdef M506F_FLAG_EN
  logic [5:0]  flag;
  logic [5:0]  flag_clr;
`endif

  m506_filtered_converter #(
    .CHANNELS(6),
    .GATES   (3),
    .DEBOUNCE(4),
    .CNT_W   (3)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in_n         (in_n),
    .gate         (gate),
    .out_n        (out_n),
    .assert_pulse (assert_pulse),
    .release_pulse(release_pulse)
`ifdef M506F_FLAG_EN
    ,
    .flag         (flag),
    .flag_clr     (flag_clr)
`endif
  );

  typedef struct {
    int         cyc;
    logic [5:0] ap;
    logic [5:0] rp;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Inputs are driven at a negedge; the change is accepted on the 6th following posedge.
  task automatic expect_event(input logic [5:0] ap, input logic [5:0] rp);
    exp_t e;
    e.cyc = cyc + 6;
    e.ap  = ap;
    e.rp  = rp;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!reset && ((assert_pulse | release_pulse) != 6'h00)) begin
      if (q.size() == 0) begin
        check("unexpected_pulse", {20'h0, assert_pulse, release_pulse}, 32'h0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("pulse_cycle", cyc, e.cyc);
        check("assert_pulse", {26'h0, assert_pulse}, {26'h0, e.ap});
        check("release_pulse", {26'h0, release_pulse}, {26'h0, e.rp});
      end
    end
  end

  initial begin
    reset = 1'b1;
    in_n  = 6'($urandom);
    gate  = 18'($urandom);
`ifdef M506F_FLAG_EN
    flag_clr = 6'($urandom);
`endif
    tick(3);
    // 1: reset state with random inputs
    check("reset_out_n", {26'h0, out_n}, 32'h3F);
    check("reset_pulses", {20'h0, assert_pulse, release_pulse}, 32'h0);
`ifdef M506F_FLAG_EN
    check("reset_flag", {26'h0, flag}, 32'h0);
    flag_clr = 6'h00;
`endif
    in_n  = 6'h3F;
    gate  = 18'h3FFFF;
    tick(1);
    reset = 1'b0;
    tick(4);

    // 2: assert channel 0
    in_n[0] = 1'b0;
    expect_event(6'b000001, 6'b000000);
    tick(5);
    check("ch0_before_latency", {31'h0, out_n[0]}, 32'h1);
    tick(3);
    check("ch0_asserted", {26'h0, out_n}, 32'h3E);

    // 3: 3-low/1-high bursts on channel 2 never get through
    for (int i = 0; i < 10; i++) begin
      in_n[2] = 1'b0;
      tick(3);
      in_n[2] = 1'b1;
      tick(1);
    end
    tick(6);
    check("ch2_glitch", {26'h0, out_n}, 32'h3E);

    // 4: gate 1 of channel 3 blocks, then releases
    gate[10] = 1'b0;
    in_n[3]  = 1'b0;
    tick(10);
    check("ch3_gated", {26'h0, out_n}, 32'h3E);
    gate[10] = 1'b1;
    expect_event(6'b001000, 6'b000000);
    tick(8);
    check("ch3_ungated", {26'h0, out_n}, 32'h36);

    // 5: multi-channel release
    in_n[5] = 1'b0;
    expect_event(6'b100000, 6'b000000);
    tick(8);
    check("ch5_asserted", {26'h0, out_n}, 32'h16);
    in_n[0] = 1'b1;
    in_n[5] = 1'b1;
    expect_event(6'b000000, 6'b100001);
    tick(8);
    check("ch0_ch5_released", {26'h0, out_n}, 32'h37);

    // Release of ch3 interrupted by reset at cnt=2; ch4 asserted across the reset
    in_n[3] = 1'b1;
    tick(4);
    in_n[4] = 1'b0;
    reset   = 1'b1;
    tick(1);
    check("reset_mid_out_n", {26'h0, out_n}, 32'h3F);
    check("reset_mid_pulses", {20'h0, assert_pulse, release_pulse}, 32'h0);
    tick(2);
    reset = 1'b0;
    expect_event(6'b010000, 6'b000000);
    tick(5);
    check("ch4_before_latency", {26'h0, out_n}, 32'h3F);
    tick(3);
    check("ch4_reaccepted", {26'h0, out_n}, 32'h2F);

`ifdef M506F_FLAG_EN
    check("flag4_set", {26'h0, flag}, 32'h10);
    // 6: clear held in the pulse cycle loses to the set
    in_n[1] = 1'b0;
    expect_event(6'b000010, 6'b000000);
    tick(6);
    flag_clr[1] = 1'b1;
    tick(1);
    check("flag1_set_wins", {26'h0, flag}, 32'h12);
    tick(1);
    check("flag1_cleared", {26'h0, flag}, 32'h10);
    flag_clr = 6'h10;
    tick(1);
    check("flag4_cleared", {26'h0, flag}, 32'h00);
    flag_clr = 6'h00;
`endif

    tick(10);
    check("events_outstanding", q.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
